// File: rtl/gp_regbank_pkg.sv
// Shared definitions for the gp_regbank register bank: word types and the
// helper that picks a word's type out of the W1C mask.
package gp_regbank_pkg;

  typedef enum logic {
    REG_RW  = 1'b0,
    REG_W1C = 1'b1
  } reg_type_e;

  // The mask is passed zero-extended to 32 bits, so at most 32 words are supported.
  localparam int unsigned MAX_REGS = 32;

  function automatic reg_type_e word_type(input logic [MAX_REGS-1:0] mask,
                                          input int unsigned idx);
    return mask[idx] ? REG_W1C : REG_RW;
  endfunction

endpackage

// File: rtl/gp_regbank_if.sv
// Host-side strobe bus of gp_regbank: active-low read/write strobes, address,
// write data, and the registered read response with its error flag.
interface gp_regbank_if #(
  parameter int bus_width = 15,
  parameter int ADDR_W    = 2
);
  logic                wrb;
  logic                rdb;
  logic [ADDR_W-1:0]   addr;
  logic [bus_width:0]  din;
  logic [bus_width:0]  rdout;
  logic                rd_valid;
  logic                addr_err;

  modport master (
    output wrb, rdb, addr, din,
    input  rdout, rd_valid, addr_err
  );

  modport slave (
    input  wrb, rdb, addr, din,
    output rdout, rd_valid, addr_err
  );
endinterface

// File: rtl/gp_reg_word.sv
// One register word of gp_regbank: plain RW or write-1-to-clear status.
// GP_REGBANK_SHADOW_EN adds a shadow stage to RW words, copied on commit.
module gp_reg_word
  import gp_regbank_pkg::*;
#(
  parameter int                 bus_width = 15,
  parameter reg_type_e          REG_TYPE  = REG_RW,
  parameter logic [bus_width:0] RESET_VAL = '0
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               we,
  input  logic               commit,
  input  logic [bus_width:0] din,
  input  logic [bus_width:0] event_in,
  output logic [bus_width:0] q,
  output logic [bus_width:0] nxt
);

  if (REG_TYPE == REG_W1C) begin : g_w1c
    // Set requests are ORed in after the clear, so a set wins over a same-edge clear.
    assign nxt = (q & ~(we ? din : '0)) | event_in;

    logic unused_commit;
    assign unused_commit = commit;
  end else begin : g_rw
`ifdef GP_REGBANK_SHADOW_EN
    logic [bus_width:0] shadow;

    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)  shadow <= RESET_VAL;
      else if (we) shadow <= din;
    end

    // Commit copies the pre-edge shadow; a same-edge write waits for the next commit.
    assign nxt = commit ? shadow : q;
`else
    assign nxt = we ? din : q;

    logic unused_commit;
    assign unused_commit = commit;
`endif
    logic [bus_width:0] unused_event;
    assign unused_event = event_in;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) q <= (REG_TYPE == REG_W1C) ? '0 : RESET_VAL;
    else        q <= nxt;
  end

endmodule

// File: rtl/gp_regbank.sv
// gp_regbank: NUM_REGS-word register bank with RW/W1C words, registered read
// path, address error pulse and interrupt summary. Optional feature macro: GP_REGBANK_SHADOW_EN.
module gp_regbank
  import gp_regbank_pkg::*;
#(
  parameter int                  bus_width = 15,
  parameter int                  NUM_REGS  = 4,
  parameter int                  ADDR_W    = 2,
  parameter logic [NUM_REGS-1:0] W1C_MASK  = '0,
  parameter logic [bus_width:0]  RESET_VAL = '0
) (
  input  logic                              sysclk,
  input  logic                              reset,
  gp_regbank_if.slave                       bus,
  input  logic [NUM_REGS*(bus_width+1)-1:0] event_in,
  input  logic                              commit,
  output logic [NUM_REGS*(bus_width+1)-1:0] regs_out,
  output logic                              irq
);

  localparam int W = bus_width + 1;

  logic [bus_width:0] words [NUM_REGS];
  logic [bus_width:0] nxt   [NUM_REGS];
  logic [bus_width:0] rd_word;
  logic               in_range;
  logic               irq_next;

  assign in_range = (32'(bus.addr) < 32'(NUM_REGS));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    logic we;
    assign we = !bus.wrb && (32'(bus.addr) == 32'(i));

    gp_reg_word #(
      .bus_width (bus_width),
      .REG_TYPE  (word_type(MAX_REGS'(W1C_MASK), i)),
      .RESET_VAL (RESET_VAL)
    ) u_word (
      .sysclk   (sysclk),
      .reset    (reset),
      .we       (we),
      .commit   (commit),
      .din      (bus.din),
      .event_in (event_in[i*W +: W]),
      .q        (words[i]),
      .nxt      (nxt[i])
    );

    assign regs_out[i*W +: W] = words[i];
  end

  // Out-of-range addresses match no word, so the mux yields zero for them.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(bus.addr) == i) rd_word = words[i];
    end
  end

  always_comb begin
    irq_next = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      irq_next = irq_next | ((|nxt[i]) & W1C_MASK[i]);
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      bus.rdout    <= '0;
      bus.rd_valid <= 1'b0;
      bus.addr_err <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (!bus.rdb) bus.rdout <= rd_word;
      bus.rd_valid <= !bus.rdb;
      bus.addr_err <= (!bus.rdb || !bus.wrb) && !in_range;
      irq          <= irq_next;
    end
  end

endmodule

// File: tb/tb_gp_regbank.sv
// Directed self-checking bench for gp_regbank (4 words, word 3 W1C, 3-bit address).
module tb_gp_regbank;

  localparam int BW = 15;
  localparam int NR = 4;
  localparam int AW = 3;

  logic              sysclk = 1'b0;
  logic              reset;
  logic [NR*16-1:0]  event_in;
  logic              commit;
  logic [NR*16-1:0]  regs_out;
  logic              irq;

  int passed = 0;
  int total  = 0;

  gp_regbank_if #(.bus_width(BW), .ADDR_W(AW)) bus ();

  gp_regbank #(
    .bus_width (BW),
    .NUM_REGS  (NR),
    .ADDR_W    (AW),
    .W1C_MASK  (4'b1000),
    .RESET_VAL (16'h0000)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .bus      (bus),
    .event_in (event_in),
    .commit   (commit),
    .regs_out (regs_out),
    .irq      (irq)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  function automatic logic [15:0] word(input int i);
    return regs_out[i*16 +: 16];
  endfunction

  // Under the shadow build, RW writes need a commit to reach the live word.
  task automatic settle_write();
`ifdef GP_REGBANK_SHADOW_EN
    commit = 1'b1;
    tick();
    commit = 1'b0;
`endif
  endtask

  initial begin
    reset    = 1'b0;
    bus.wrb  = 1'b1;
    bus.rdb  = 1'b1;
    bus.addr = '0;
    bus.din  = '0;
    event_in = '0;
    commit   = 1'b0;
    tick();
    tick();

    chk("rst_rdout",    64'(bus.rdout),    64'h0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
    chk("rst_addr_err", 64'(bus.addr_err), 64'h0);
    chk("rst_irq",      64'(irq),          64'h0);
    chk("rst_regs",     regs_out,          64'h0);

    reset = 1'b1;
    tick();
    chk("idle_rd_valid", 64'(bus.rd_valid), 64'h0);

    // Back-to-back reads of every word.
    for (int i = 0; i < 4; i++) begin
      bus.rdb  = 1'b0;
      bus.addr = 3'(i);
      tick();
      chk($sformatf("rd%0d_data", i),  64'(bus.rdout),    64'h0);
      chk($sformatf("rd%0d_valid", i), 64'(bus.rd_valid), 64'h1);
    end
    bus.rdb = 1'b1;
    tick();
    chk("rd_valid_drop", 64'(bus.rd_valid), 64'h0);

    // RW write then read.
    bus.wrb  = 1'b0;
    bus.addr = 3'd1;
    bus.din  = 16'hA5A5;
    tick();
    bus.wrb = 1'b1;
`ifdef GP_REGBANK_SHADOW_EN
    chk("wr1_shadowed", 64'(word(1)), 64'h0);
`endif
    settle_write();
    chk("wr1_regs", 64'(word(1)), 64'hA5A5);
    bus.rdb = 1'b0;
    tick();
    chk("rd1_data",  64'(bus.rdout),    64'hA5A5);
    chk("rd1_valid", 64'(bus.rd_valid), 64'h1);

    // Same-edge read and write returns the old value.
    bus.wrb = 1'b0;
    bus.din = 16'h5A5A;
    tick();
    bus.wrb = 1'b1;
    bus.rdb = 1'b1;
    chk("rdwr_old", 64'(bus.rdout), 64'hA5A5);
    settle_write();
    chk("rdwr_regs", 64'(word(1)), 64'h5A5A);
    bus.rdb = 1'b0;
    tick();
    bus.rdb = 1'b1;
    chk("rdwr_new", 64'(bus.rdout), 64'h5A5A);

    // W1C: event sets bit 3 of word 3; events on an RW word are ignored.
    event_in = {16'h0008, 16'h0000, 16'h0000, 16'hFFFF};
    tick();
    event_in = '0;
    chk("evt_word3", 64'(word(3)), 64'h0008);
    chk("evt_irq",   64'(irq),     64'h1);
    chk("evt_word0", 64'(word(0)), 64'h0);
    tick();
    chk("evt_hold", 64'(word(3)), 64'h0008);

    // Writing zeros clears nothing.
    bus.wrb  = 1'b0;
    bus.addr = 3'd3;
    bus.din  = 16'h0000;
    tick();
    chk("w1c_zero", 64'(word(3)), 64'h0008);

    bus.din = 16'h0008;
    tick();
    bus.wrb = 1'b1;
    chk("w1c_clr",     64'(word(3)), 64'h0);
    chk("w1c_clr_irq", 64'(irq),     64'h0);

    // Set wins over a simultaneous clear.
    bus.wrb  = 1'b0;
    event_in = {16'h0008, 48'h0};
    tick();
    bus.wrb  = 1'b1;
    event_in = '0;
    chk("w1c_setwin",     64'(word(3)), 64'h0008);
    chk("w1c_setwin_irq", 64'(irq),     64'h1);

    // Out-of-range write.
    bus.wrb  = 1'b0;
    bus.addr = 3'd5;
    bus.din  = 16'hFFFF;
    tick();
    bus.wrb = 1'b1;
    chk("oor_wr_err",   64'(bus.addr_err), 64'h1);
    chk("oor_wr_valid", 64'(bus.rd_valid), 64'h0);
    chk("oor_wr_regs",  regs_out,          64'h0008_0000_5A5A_0000);
    tick();
    chk("oor_err_drop", 64'(bus.addr_err), 64'h0);

    // Out-of-range read.
    bus.rdb = 1'b0;
    tick();
    bus.rdb = 1'b1;
    chk("oor_rd_data",  64'(bus.rdout),    64'h0);
    chk("oor_rd_valid", 64'(bus.rd_valid), 64'h1);
    chk("oor_rd_err",   64'(bus.addr_err), 64'h1);
    tick();
    chk("oor_rd_drop", 64'(bus.addr_err), 64'h0);

    // Reset between a read strobe and its edge.
    bus.rdb  = 1'b0;
    bus.addr = 3'd1;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_regs",  regs_out, 64'h0);
    chk("midrst_irq",   64'(irq), 64'h0);
    @(posedge sysclk);
    #1;
    chk("midrst_valid", 64'(bus.rd_valid), 64'h0);
    chk("midrst_rdout", 64'(bus.rdout),    64'h0);
    bus.rdb = 1'b1;
    reset   = 1'b1;
    tick();
    chk("postrst_valid", 64'(bus.rd_valid), 64'h0);

    // Write 0x1234 to word 0, then read before and after a commit.
    bus.wrb  = 1'b0;
    bus.addr = 3'd0;
    bus.din  = 16'h1234;
    tick();
    bus.wrb = 1'b1;
    bus.rdb = 1'b0;
    tick();
    bus.rdb = 1'b1;
`ifdef GP_REGBANK_SHADOW_EN
    chk("shadow_precommit", 64'(bus.rdout), 64'h0);
    chk("shadow_live",      64'(word(0)),   64'h0);
`else
    chk("direct_write", 64'(bus.rdout), 64'h1234);
`endif
    commit = 1'b1;
    tick();
    commit  = 1'b0;
    bus.rdb = 1'b0;
    tick();
    bus.rdb = 1'b1;
    chk("commit_read", 64'(bus.rdout), 64'h1234);
    chk("commit_regs", 64'(word(0)),   64'h1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
